// File: rtl/mlp_noc_bridge_if.sv
// Avalon-MM slave bus plus TX/RX AXI-Stream channels of the MLP NoC bridge.
// The bridge uses the slave modport; the host/NoC side uses master.
interface mlp_noc_bridge_if #(
    parameter int unsigned DATAW = 128,
    parameter int unsigned IDW   = 4,
    parameter int unsigned DESTW = 12,
    parameter int unsigned USERW = 75,
    parameter int unsigned ADDRW = 6
);
    logic [ADDRW-1:0] address;
    logic             chipselect;
    logic             read;
    logic             write;
    logic [31:0]      writedata;
    logic [31:0]      readdata;

    logic             axis_s_tvalid;
    logic             axis_s_tready;
    logic [DATAW-1:0] axis_s_tdata;
    logic             axis_s_tlast;
    logic [IDW-1:0]   axis_s_tid;
    logic [USERW-1:0] axis_s_tuser;
    logic [DESTW-1:0] axis_s_tdest;

    logic             axis_m_tvalid;
    logic             axis_m_tready;
    logic [DATAW-1:0] axis_m_tdata;
    logic             axis_m_tlast;
    logic [IDW-1:0]   axis_m_tid;
    logic [USERW-1:0] axis_m_tuser;
    logic [DESTW-1:0] axis_m_tdest;

    modport slave (
        input  address, chipselect, read, write, writedata,
        output readdata,
        output axis_s_tvalid, axis_s_tdata, axis_s_tlast, axis_s_tid, axis_s_tuser, axis_s_tdest,
        input  axis_s_tready,
        input  axis_m_tvalid, axis_m_tdata, axis_m_tlast, axis_m_tid, axis_m_tuser, axis_m_tdest,
        output axis_m_tready
    );

    modport master (
        output address, chipselect, read, write, writedata,
        input  readdata,
        input  axis_s_tvalid, axis_s_tdata, axis_s_tlast, axis_s_tid, axis_s_tuser, axis_s_tdest,
        output axis_s_tready,
        output axis_m_tvalid, axis_m_tdata, axis_m_tlast, axis_m_tid, axis_m_tuser, axis_m_tdest,
        input  axis_m_tready
    );
endinterface

// File: rtl/mlp_noc_bridge.sv
// Avalon-MM slave to AXI-Stream bridge: host-staged TX beats to the NoC, RX FIFO drained by the host.
// Optional interrupt logic and irq port are enabled by defining MLP_NOC_BRIDGE_IRQ_EN.
module mlp_noc_bridge #(
    parameter int unsigned DATAW    = 128,
    parameter int unsigned IDW      = 4,
    parameter int unsigned DESTW    = 12,
    parameter int unsigned USERW    = 75,
    parameter int unsigned RX_DEPTH = 4,
    parameter int unsigned ADDRW    = 6
) (
    input  logic clk,
    input  logic reset_n,
    mlp_noc_bridge_if.slave bus
`ifdef MLP_NOC_BRIDGE_IRQ_EN
    ,
    output logic irq
`endif
);
    localparam int unsigned WORDS = DATAW / 32;
    localparam int unsigned IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned PW    = $clog2(RX_DEPTH);
    localparam int unsigned CW    = PW + 1;
    localparam int unsigned HW    = ADDRW - 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

    tx_state_t state, state_nxt;
    logic      load_c;

    logic [WORDS-1:0][31:0] stage;
    logic [DATAW-1:0]       tx_data;
    logic [1:0]             tx_op;
    logic [DESTW-1:0]       tx_dest;
    logic                   tx_last;
    logic [1:0]             ctrl_op;
    logic [DESTW-1:0]       ctrl_dest;
    logic                   ctrl_last;
    logic                   collision;
    logic [31:0]            readdata_q;
    logic [31:0]            rd_c;

    logic [WORDS-1:0][31:0] mem [RX_DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          rx_count, count_nxt;
    logic                   rx_ready;

    // Bus decode
    logic          wr, rd, word_ok;
    logic          sel_ctrl, sel_status, sel_pop, sel_tx, sel_rx;
    logic [IW-1:0] widx;
    assign wr         = bus.chipselect & bus.write;
    assign rd         = bus.chipselect & bus.read;
    assign word_ok    = 5'(bus.address[3:0]) < 5'(WORDS);
    assign widx       = bus.address[IW-1:0];
    assign sel_ctrl   = bus.address == ADDRW'(0);
    assign sel_status = bus.address == ADDRW'(1);
    assign sel_pop    = bus.address == ADDRW'(2);
    assign sel_tx     = (bus.address[ADDRW-1:4] == HW'(1)) && word_ok;
    assign sel_rx     = (bus.address[ADDRW-1:4] == HW'(2)) && word_ok;

    logic tx_busy, send_req, hs;
    assign tx_busy  = state == SEND;
    assign send_req = wr & sel_ctrl & bus.writedata[0];
    assign hs       = bus.axis_s_tvalid & bus.axis_s_tready;

    logic push, pop, rx_full, rx_nonempty;
    assign rx_full     = rx_count == CW'(RX_DEPTH);
    assign rx_nonempty = rx_count != CW'(0);
    assign push        = bus.axis_m_tvalid & rx_ready;
    assign pop         = wr & sel_pop & rx_nonempty;

    // Sideband of returned beats is intentionally dropped
    logic unused_rx_sideband;
    assign unused_rx_sideband = ^{bus.axis_m_tlast, bus.axis_m_tid, bus.axis_m_tuser, bus.axis_m_tdest};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        case (state)
            IDLE: if (send_req) begin
                state_nxt = SEND;
                load_c    = 1'b1;
            end
            SEND: if (bus.axis_s_tready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // TX payload, control fields, staging and collision flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage     <= '0;
            tx_data   <= '0;
            tx_op     <= '0;
            tx_dest   <= '0;
            tx_last   <= 1'b0;
            ctrl_op   <= '0;
            ctrl_dest <= '0;
            ctrl_last <= 1'b0;
            collision <= 1'b0;
        end else begin
            if (wr && sel_tx) stage[widx] <= bus.writedata;
            if (wr && sel_ctrl && !(send_req && tx_busy)) begin
                ctrl_op   <= bus.writedata[2:1];
                ctrl_dest <= DESTW'(bus.writedata[14:3]);
                ctrl_last <= bus.writedata[15];
            end
            if (load_c) begin
                tx_data <= stage;
                tx_op   <= bus.writedata[2:1];
                tx_dest <= DESTW'(bus.writedata[14:3]);
                tx_last <= bus.writedata[15];
            end
            if (send_req && tx_busy)                      collision <= 1'b1;
            else if (wr && sel_status && bus.writedata[3]) collision <= 1'b0;
        end
    end

    assign bus.axis_s_tvalid = tx_busy;
    assign bus.axis_s_tdata  = tx_data;
    assign bus.axis_s_tlast  = tx_last;
    assign bus.axis_s_tid    = '0;
    assign bus.axis_s_tuser  = USERW'({tx_op, 9'b0});
    assign bus.axis_s_tdest  = tx_dest;

    always_comb begin
        count_nxt = rx_count;
        if (push && !pop)      count_nxt = rx_count + CW'(1);
        else if (!push && pop) count_nxt = rx_count - CW'(1);
    end

    // RX FIFO control; tready is registered so it rises one cycle after reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_count <= '0;
            rx_ready <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            rx_count <= count_nxt;
            rx_ready <= count_nxt != CW'(RX_DEPTH);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.axis_m_tdata;
    end

    assign bus.axis_m_tready = rx_ready;

`ifdef MLP_NOC_BRIDGE_IRQ_EN
    logic       sel_irq;
    logic [1:0] irq_en;
    logic       tx_done;
    assign sel_irq = bus.address == ADDRW'(4);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en  <= '0;
            tx_done <= 1'b0;
            irq     <= 1'b0;
        end else begin
            if (wr && sel_irq) irq_en <= bus.writedata[1:0];
            if (hs)                                     tx_done <= 1'b1;
            else if (wr && sel_irq && bus.writedata[2]) tx_done <= 1'b0;
            irq <= (irq_en[0] & rx_nonempty) | (irq_en[1] & tx_done);
        end
    end
`endif

    always_comb begin
        rd_c = '0;
        if (sel_ctrl)        rd_c = {16'b0, ctrl_last, 12'(ctrl_dest), ctrl_op, tx_busy};
        else if (sel_status) rd_c = {16'b0, 8'(rx_count), 4'b0, collision, rx_full, rx_nonempty, tx_busy};
`ifdef MLP_NOC_BRIDGE_IRQ_EN
        else if (sel_irq)    rd_c = {29'b0, tx_done, irq_en};
`endif
        else if (sel_tx)     rd_c = stage[widx];
        else if (sel_rx && rx_nonempty) rd_c = mem[rd_ptr][widx];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  readdata_q <= '0;
        else if (rd)   readdata_q <= rd_c;
    end

    assign bus.readdata = readdata_q;

endmodule
